// File: rtl/nand_cpu_pkg.sv
// rtl/nand_cpu_pkg.sv - shared types and constants for the NAND CPU and its program loader
//
// Contents:
//   INSTR_W        - instruction width in bits
//   loader_state_t - imem_loader FSM states
package nand_cpu_pkg;

    localparam int INSTR_W = 8;

    typedef enum logic [2:0] {
        LD_LEN   = 3'd0,
        LD_DATA  = 3'd1,
        LD_CHK   = 3'd2,
        LD_FLUSH = 3'd3,
        LD_RUN   = 3'd4,
        LD_ERR   = 3'd5
    } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time program loader feeding the NAND CPU instruction memory
//
// Takes a length byte followed by that many instructions over a valid/ready
// handshake. It writes the instructions to instruction memory from address 0
// and holds the CPU in reset until the final write has landed.
//
// Optional feature macro: LOADER_CHECKSUM_EN. When it is defined, one trailing
// byte equal to the XOR of all instructions is required. A mismatch parks the
// loader in ERR.
//
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   in_valid/in_ready     - byte stream handshake, in_data carries the byte
//   reload                - single-cycle request to start a new load (RUN/ERR only)
//   imem_we/addr/wdata    - registered instruction-memory write port
//   cpu_n_rst             - active-low CPU core reset, high only in RUN
//   load_err              - checksum failure flag (0 when checksum compiled out)
//   loaded_len            - instruction count of the current or last load
module imem_loader
    import nand_cpu_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_data,
    input  logic               reload,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               cpu_n_rst,
    output logic               load_err,
    output logic [ADDR_W:0]    loaded_len
);

    localparam logic [ADDR_W:0] DEPTH_LEN = (ADDR_W+1)'(DEPTH);

    loader_state_t      state_q, state_d;
    logic               ready_q, ready_d;
    logic [ADDR_W:0]    cnt_q, cnt_d;
    logic [ADDR_W:0]    len_q, len_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [INSTR_W-1:0] wdata_q, wdata_d;
`ifdef LOADER_CHECKSUM_EN
    logic [INSTR_W-1:0] acc_q, acc_d;
`endif

    logic               xfer;
    logic               last_word;
    logic [ADDR_W:0]    len_clamped;

    assign xfer      = in_valid && ready_q;
    assign last_word = (cnt_q == len_q - 1'b1);

    // A length of 0 means a full memory. Oversized lengths are clamped so that
    // the address counter can never run past DEPTH-1.
    always_comb begin
        if ((in_data == '0) || (32'(in_data) > 32'(DEPTH))) begin
            len_clamped = DEPTH_LEN;
        end else begin
            len_clamped = (ADDR_W+1)'(in_data);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef LOADER_CHECKSUM_EN
        acc_d   = acc_q;
`endif

        case (state_q)
            LD_LEN: begin
                if (xfer) begin
                    len_d   = len_clamped;
                    cnt_d   = '0;
                    state_d = LD_DATA;
                end
            end

            LD_DATA: begin
                if (xfer) begin
                    we_d    = 1'b1;
                    addr_d  = cnt_q[ADDR_W-1:0];
                    wdata_d = in_data;
                    cnt_d   = cnt_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    acc_d   = acc_q ^ in_data;
                    if (last_word) begin
                        state_d = LD_CHK;
                    end
`else
                    if (last_word) begin
                        state_d = LD_FLUSH;
                    end
`endif
                end
            end

`ifdef LOADER_CHECKSUM_EN
            LD_CHK: begin
                if (xfer) begin
                    state_d = (in_data == acc_q) ? LD_FLUSH : LD_ERR;
                end
            end
`endif

            // Gives the last registered write its cycle before the core wakes.
            LD_FLUSH: begin
                state_d = LD_RUN;
            end

            LD_RUN, LD_ERR: begin
                if (reload) begin
                    state_d = LD_LEN;
                    cnt_d   = '0;
`ifdef LOADER_CHECKSUM_EN
                    acc_d   = '0;
`endif
                end
            end

            default: begin
                state_d = LD_LEN;
            end
        endcase

        // Registered ready follows the next state, so there is no gap between
        // LEN, DATA and CHK and ready is already up in the cycle after a reload.
        ready_d = (state_d == LD_LEN) || (state_d == LD_DATA) || (state_d == LD_CHK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LD_LEN;
            ready_q <= 1'b0;
            cnt_q   <= '0;
            len_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            acc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
            acc_q   <= acc_d;
`endif
        end
    end

    assign in_ready   = ready_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_n_rst  = (state_q == LD_RUN);
    assign loaded_len = len_q;

`ifdef LOADER_CHECKSUM_EN
    assign load_err   = (state_q == LD_ERR);
`else
    assign load_err   = 1'b0;
`endif

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that sits directly upstream of the single-cycle NAND CPU's instruction memory. It accepts a byte stream over a valid/ready handshake, consisting of a length byte followed by that many 8-bit instructions, and writes the instructions into instruction memory starting at address 0. The CPU core is held in reset (`cpu_n_rst` low) for the whole load and is released only after the final write has landed. A `reload` pulse returns the block to loading at any time after a completed load.

## Interface
Parameters:
- `ADDR_W`, default 8: instruction-memory address width; equals the CPU's `PC_SIZE`.
- `DEPTH`, default 2**ADDR_W: instruction-memory depth in words.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous and active-high.
- `in_valid` in 1: upstream byte valid.
- `in_ready` out 1: loader can accept a byte.
- `in_data` in 8: upstream byte.
- `reload` in 1: single-cycle request to reload a program.
- `imem_we` out 1: instruction-memory write enable.
- `imem_addr` out ADDR_W: write address.
- `imem_wdata` out 8: write data (one instruction).
- `cpu_n_rst` out 1: active-low reset to the CPU core; high only in RUN.
- `load_err` out 1: checksum failure flag; stays 0 when checksum is compiled out.
- `loaded_len` out ADDR_W+1: instruction count of the current or last load.

## Operation
- FSM states: LEN, DATA, CHK, FLUSH, RUN, ERR.
- Reset: state goes to LEN; all outputs 0 (`in_ready`, `imem_we`, `imem_addr`, `imem_wdata`, `cpu_n_rst`, `load_err`, `loaded_len`); byte counter and checksum accumulator cleared.
- A byte transfers when `in_valid && in_ready`. `in_ready` is 1 in LEN, DATA and CHK, and 0 in all other states. `in_data` is ignored when no transfer happens.
- **LEN:**
  - A transfer latches L = `in_data`.
  - L = 0 means DEPTH words, so `loaded_len` = DEPTH (width ADDR_W+1 holds this).
  - L > DEPTH is clamped to DEPTH.
  - Next state is DATA; counter cleared.
- **DATA:**
  - Each transfer writes `in_data` to address = counter.
  - Counter increments; checksum accumulator updates with `acc ^= in_data`.
  - The transfer of word `loaded_len`-1 moves the FSM to CHK if `LOADER_CHECKSUM_EN` is defined, otherwise to FLUSH.
- **CHK:**
  - On a transfer, compare `in_data` with `acc`.
  - Equal: go to FLUSH.
  - Not equal: go to ERR with `load_err` = 1.
- **FLUSH:** one cycle; lets the last registered write complete. Next state RUN.
- **RUN:** `cpu_n_rst` = 1.
- **ERR:** `cpu_n_rst` = 0 and `load_err` = 1 until `reload` or `rst`.
- **`reload`:**
  - In RUN or ERR: go to LEN, drive `cpu_n_rst` = 0 from the next cycle, clear `load_err`, counter and `acc`.
  - In LEN, DATA or CHK: ignored, so a partial load is never aborted by `reload`. Only `rst` aborts.
- **`rst` mid-load:** immediate return to LEN. Instruction-memory contents already written stay as they are; no rollback.
- Address counter never wraps: clamping L guarantees the last address is at most DEPTH-1.

## Timing
- Write latency: a byte transferred in cycle t appears on `imem_we`/`imem_addr`/`imem_wdata` in cycle t+1 (registered). `imem_we` is 0 in every other cycle.
- Throughput: one byte per cycle; `in_ready` does not drop between LEN, DATA and CHK.
- Release: last data byte (or checksum byte) transferred at t; FLUSH at t+1 (the last write is also driven at t+1); `cpu_n_rst` rises at t+2.
- `reload` sampled at cycle t in RUN: `cpu_n_rst` = 0 and `in_ready` = 1 at t+1.
- `rst` and `reload` in the same cycle: `rst` wins.

## Configuration
- Macro: `LOADER_CHECKSUM_EN`.
- Defined: CHK state exists; one extra trailing byte is required, equal to the XOR of all L instruction bytes. A mismatch goes to ERR.
- Undefined: no CHK state, no accumulator logic; `load_err` is tied to 0 and DATA goes directly to FLUSH.

## Structure
- Shared package `nand_cpu_pkg`: `loader_state_t` enum (LEN, DATA, CHK, FLUSH, RUN, ERR) and the instruction width constant (8).
- No sub-module: FSM, counter and accumulator are small enough for a single module.
- The CPU top instantiates `imem_loader` and wires `cpu_n_rst` to the core's `n_rst` and the `imem_*` outputs to the `i_mem` write port.

## Test plan
- **Basic load, checksum off:** stream 0x03, 0xA1, 0xB2, 0xC3 back-to-back -> writes (0, A1), (1, B2), (2, C3) on consecutive cycles; `cpu_n_rst` = 1 two cycles after the 0xC3 transfer; `loaded_len` = 3.
- **Checksum on:** 0x02, 0x0F, 0xF0, 0xFF -> RUN. Same stream with final byte 0x00 -> ERR, `load_err` = 1, `cpu_n_rst` stays 0.
- **Length 0 (ADDR_W = 4):** 0x00 followed by 16 bytes -> 16 writes to addresses 0-15, `loaded_len` = 16. Length 0x20 -> clamped to 16 writes.
- **Backpressure gaps:** random `in_valid` gaps in DATA -> writes only one cycle after a transfer, addresses contiguous, no duplicate writes.
- **`reload` in RUN:** `cpu_n_rst` falls next cycle, a new load overwrites address 0. `reload` pulsed in DATA -> ignored, load completes normally.
- **`rst` after 2 of 5 bytes:** state LEN and all outputs 0 on the next cycle; a fresh load then succeeds.
